wb_sram_march_bist: RTL

//  Wishbone classic master running a March C- test on the 1024x32 SRAM Wishbone slave port.

---
 rtl/wb_sram_bist_pkg.sv | 40 ++++
 rtl/wb_sram_march_bist_march_seq.sv | 70 +++++++
 rtl/wb_sram_march_bist.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_sram_bist_pkg.sv
// Shared types for the SRAM March C- BIST.
//   state_t    : Wishbone master FSM states
//   elem_t     : per-element descriptor (direction, op count, op kinds)
//   elem_info  : March C- element table lookup
package wb_sram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    GAP,
    DONE
  } state_t;

  localparam int unsigned N_ELEM = 6;

  // down=1 walks DEPTH-1..0; two_ops=0 means only op0 is performed.
  // inv=1 selects ~P instead of P for the write data / read expectation.
  typedef struct packed {
    logic down;
    logic two_ops;
    logic op0_we;
    logic op0_inv;
    logic op1_we;
    logic op1_inv;
  } elem_t;

  function automatic elem_t elem_info(input logic [2:0] e);
    elem_t r;
    unique case (e)
      3'd0:    r = '{down: 1'b0, two_ops: 1'b0, op0_we: 1'b1, op0_inv: 1'b0, op1_we: 1'b0, op1_inv: 1'b0};
      3'd1:    r = '{down: 1'b0, two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b0, op1_we: 1'b1, op1_inv: 1'b1};
      3'd2:    r = '{down: 1'b0, two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b1, op1_we: 1'b1, op1_inv: 1'b0};
      3'd3:    r = '{down: 1'b1, two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b0, op1_we: 1'b1, op1_inv: 1'b1};
      3'd4:    r = '{down: 1'b1, two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b1, op1_we: 1'b1, op1_inv: 1'b0};
      default: r = '{down: 1'b0, two_ops: 1'b0, op0_we: 1'b0, op0_inv: 1'b0, op1_we: 1'b0, op1_inv: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_sram_march_bist_march_seq.sv
// March C- sequencer: walks element -> address -> op and presents the
// current operation.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart at E0, address 0, op 0
//   advance    : step to the next operation
//   we, inv    : current op is a write / uses ~P
//   elem, addr : current element and word index
//   last       : current op is the final op of the final element
module march_seq
  import wb_sram_bist_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic          we,
  output logic          inv,
  output logic [2:0]    elem,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [2:0]    elem_q;
  logic [AW-1:0] addr_q;
  logic          op_q;
  elem_t         info;
  elem_t         info_next;
  logic          last_op;
  logic          addr_end;

  always_comb begin
    info      = elem_info(elem_q);
    info_next = elem_info(elem_q + 3'd1);
    we        = op_q ? info.op1_we  : info.op0_we;
    inv       = op_q ? info.op1_inv : info.op0_inv;
    // Single-op elements finish on op 0, two-op elements on op 1.
    last_op   = (op_q == info.two_ops);
    addr_end  = info.down ? (addr_q == '0) : (addr_q == '1);
    last      = last_op && addr_end && (elem_q == 3'(N_ELEM - 1));
    elem      = elem_q;
    addr      = addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q <= '0;
      addr_q <= '0;
      op_q   <= 1'b0;
    end else if (clear) begin
      elem_q <= '0;
      addr_q <= '0;
      op_q   <= 1'b0;
    end else if (advance) begin
      if (!last_op) begin
        op_q <= 1'b1;
      end else begin
        op_q <= 1'b0;
        if (addr_end) begin
          elem_q <= elem_q + 3'd1;
          addr_q <= info_next.down ? '1 : '0;
        end else begin
          addr_q <= info.down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_sram_march_bist.sv
// Wishbone classic master running March C- on a 2**AW x 32 SRAM.
//   wb_clk_i, wb_rst_ni        : clock, async active-low reset
//   start_i, pattern_i         : start request (rising edge), background P
//   wbm_*                      : Wishbone master port
//   busy_o, done_o             : test running / finished
//   fail_o, timeout_o          : read mismatch / missing ack
//   fail_elem_o, fail_addr_o,
//   fail_data_o                : location and read data of first failure
module wb_sram_march_bist
  import wb_sram_bist_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned AW        = 10,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic [31:0]   pattern_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          fail_o,
  output logic          timeout_o,
  output logic [2:0]    fail_elem_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [31:0]   fail_data_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic          start_q;
  logic [31:0]   pat_q;
  logic [TW-1:0] tcnt;
  logic          done_q, fail_q, tmo_q;
  logic [2:0]    felem_q;
  logic [AW-1:0] faddr_q;
  logic [31:0]   fdata_q;

  logic          seq_we, seq_inv, seq_last;
  logic [2:0]    seq_elem;
  logic [AW-1:0] seq_addr;

  logic          launch;
  logic [31:0]   exp_data;
  logic          mismatch;
  logic          tmo_hit;

  march_seq #(.AW(AW)) u_seq (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (launch),
    .advance ((state == GAP) && !seq_last),
    .we      (seq_we),
    .inv     (seq_inv),
    .elem    (seq_elem),
    .addr    (seq_addr),
    .last    (seq_last)
  );

  always_comb begin
    launch   = start_i && !start_q && ((state == IDLE) || (state == DONE));
    exp_data = seq_inv ? ~pat_q : pat_q;
    mismatch = (state == BUS) && wbm_ack_i && !seq_we && (wbm_dat_i != exp_data);
    // ack has priority: timeout only fires on a cycle without ack.
    tmo_hit  = (state == BUS) && !wbm_ack_i && (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (launch) state_next = BUS;
      BUS: begin
        if (wbm_ack_i)    state_next = mismatch ? DONE : GAP;
        else if (tmo_hit) state_next = DONE;
      end
      GAP:     state_next = seq_last ? DONE : BUS;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs decode directly from the state register so reset drops
  // cyc/stb without waiting for a clock.
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    busy_o    = 1'b0;
    unique case (state)
      BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = seq_we;
        wbm_sel_o = '1;
        wbm_adr_o = BASE_ADDR + 32'({seq_addr, 2'b00});
        wbm_dat_o = seq_we ? exp_data : '0;
        busy_o    = 1'b1;
      end
      GAP:     busy_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      start_q <= 1'b0;
      pat_q   <= '0;
      tcnt    <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      felem_q <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      start_q <= start_i;
      tcnt    <= ((state == BUS) && !wbm_ack_i) ? tcnt + 1'b1 : '0;
      if (launch) begin
        pat_q   <= pattern_i;
        done_q  <= 1'b0;
        fail_q  <= 1'b0;
        tmo_q   <= 1'b0;
        felem_q <= '0;
        faddr_q <= '0;
        fdata_q <= '0;
      end else if (mismatch) begin
        done_q  <= 1'b1;
        fail_q  <= 1'b1;
        felem_q <= seq_elem;
        faddr_q <= seq_addr;
        fdata_q <= wbm_dat_i;
      end else if (tmo_hit) begin
        done_q  <= 1'b1;
        tmo_q   <= 1'b1;
        felem_q <= seq_elem;
        faddr_q <= seq_addr;
        fdata_q <= '0;
      end else if ((state == GAP) && seq_last) begin
        done_q  <= 1'b1;
      end
    end
  end

  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign timeout_o   = tmo_q;
  assign fail_elem_o = felem_q;
  assign fail_addr_o = faddr_q;
  assign fail_data_o = fdata_q;

endmodule
